// File: rtl/r4_ibf_stream.sv
// r4_ibf_stream: streaming inverse radix-4 butterfly for the IFFT path.
// Collects four complex samples x0..x3, computes f_k = sum_n x_n * (+i)^(n*k) in one cycle,
// optionally scales by 1/4 (arithmetic shift, floor), then emits f0..f3 one per handshake.
// Groups never overlap: input is stalled while a group is being computed or emitted.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   input sample valid
//   in_ready   block can accept a sample (only while collecting)
//   in_r/in_i  input sample, signed W-bit real/imag
//   out_valid  output sample valid
//   out_ready  downstream accepts the output
//   out_r/out_i output sample f_k, signed W-bit real/imag
//   out_idx    index k of the presented f_k
//   out_last   high with f3
//   busy       high whenever a group is partially collected, computing or emitting
module r4_ibf_stream #(
  parameter int unsigned W     = 16,
  parameter bit          SCALE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_r,
  input  logic signed [W-1:0] in_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_r,
  output logic signed [W-1:0] out_i,
  output logic [1:0]          out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned WE = W + 2;

  typedef enum logic [1:0] {
    StCollect,
    StCompute,
    StEmit
  } state_e;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       capture;
  logic       load;

  logic signed [W-1:0]  xr_q [4];
  logic signed [W-1:0]  xi_q [4];
  logic signed [W-1:0]  fr_q [4];
  logic signed [W-1:0]  fi_q [4];
  logic signed [WE-1:0] er   [4];
  logic signed [WE-1:0] ei   [4];
  logic signed [WE-1:0] sum_r [4];
  logic signed [WE-1:0] sum_i [4];
  logic signed [W-1:0]  res_r [4];
  logic signed [W-1:0]  res_i [4];

  // Butterfly: multiplying by i maps (a, b) to (-b, a).
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      er[n] = {{2{xr_q[n][W-1]}}, xr_q[n]};
      ei[n] = {{2{xi_q[n][W-1]}}, xi_q[n]};
    end
    sum_r[0] = er[0] + er[1] + er[2] + er[3];
    sum_i[0] = ei[0] + ei[1] + ei[2] + ei[3];
    sum_r[1] = er[0] - ei[1] - er[2] + ei[3];
    sum_i[1] = ei[0] + er[1] - ei[2] - er[3];
    sum_r[2] = er[0] - er[1] + er[2] - er[3];
    sum_i[2] = ei[0] - ei[1] + ei[2] - ei[3];
    sum_r[3] = er[0] + ei[1] - er[2] - ei[3];
    sum_i[3] = ei[0] - er[1] - ei[2] + er[3];
    for (int k = 0; k < 4; k++) begin
      if (SCALE) begin
        res_r[k] = W'(sum_r[k] >>> 2);
        res_i[k] = W'(sum_i[k] >>> 2);
      end else begin
        res_r[k] = sum_r[k][W-1:0];
        res_i[k] = sum_i[k][W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      StCollect: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          cnt_d   = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) state_d = StCompute;
        end
      end
      StCompute: begin
        load    = 1'b1;
        idx_d   = 2'd0;
        state_d = StEmit;
      end
      StEmit: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // On the final accept idx stays at 3 so the outputs hold f3 while idle;
          // it is cleared on entry to the next emit.
          if (idx_q == 2'd3) state_d = StCollect;
          else               idx_d   = 2'(idx_q + 2'd1);
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StCollect;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        fr_q[k] <= '0;
        fi_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (load) begin
        for (int k = 0; k < 4; k++) begin
          fr_q[k] <= res_r[k];
          fi_q[k] <= res_i[k];
        end
      end
    end
  end

  // Sample store needs no reset: all four slots are rewritten before every compute.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      xr_q[cnt_q] <= in_r;
      xi_q[cnt_q] <= in_i;
    end
  end

  assign out_r    = fr_q[idx_q];
  assign out_i    = fi_q[idx_q];
  assign out_idx  = idx_q;
  assign out_last = (idx_q == 2'd3);
  assign busy     = (state_q != StCollect) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_r4_ibf_stream.sv
module tb_r4_ibf_stream;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic signed [15:0] in_r, in_i;
  logic in_ready, out_valid, out_last, busy;
  logic signed [15:0] out_r, out_i;
  logic [1:0] out_idx;
  logic in_ready0, out_valid0, out_last0, busy0;
  logic signed [15:0] out_r0, out_i0;
  logic [1:0] out_idx0;

  int checks = 0;
  int errors = 0;

  int gx_r [4];
  int gx_i [4];
  int got_r [4];
  int got_i [4];
  int got0_r [4];
  int got0_i [4];
  int got_idx [4];
  int got_last [4];
  int lat;
  bit tmo;
  int sent_r [400];
  int sent_i [400];

  r4_ibf_stream #(.W(16), .SCALE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
    .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  r4_ibf_stream #(.W(16), .SCALE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_r(in_r),
    .in_i(in_i), .out_valid(out_valid0), .out_ready(out_ready), .out_r(out_r0), .out_i(out_i0),
    .out_idx(out_idx0), .out_last(out_last0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: f_k = sum x_n * i^(n*k) over sent group g.
  function automatic logic [31:0] mdl(input int g, input int k, input bit sc);
    int sr, si, a, b;
    logic [31:0] res;
    sr = 0;
    si = 0;
    for (int n = 0; n < 4; n++) begin
      a = sent_r[4*g+n];
      b = sent_i[4*g+n];
      case ((n * k) % 4)
        0: begin sr += a; si += b; end
        1: begin sr -= b; si += a; end
        2: begin sr -= a; si -= b; end
        default: begin sr += b; si -= a; end
      endcase
    end
    if (sc) begin
      sr = sr >>> 2;
      si = si >>> 2;
    end
    res = {16'(sr), 16'(si)};
    return res;
  endfunction

  task automatic send_sample(input int r, input int i);
    bit hs;
    int c;
    in_valid = 1'b1;
    in_r = 16'(r);
    in_i = 16'(i);
    c = 0;
    do begin
      hs = in_ready;
      step();
      c++;
    end while (!hs && c < 200);
    in_valid = 1'b0;
    if (!hs) tmo = 1'b1;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_r = 16'sd1234;
    in_i = -16'sd77;
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_group();
    tmo = 1'b0;
    for (int n = 0; n < 4; n++) send_sample(gx_r[n], gx_i[n]);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!out_valid) tmo = 1'b1;
      got_r[k] = int'(out_r);
      got_i[k] = int'(out_i);
      got0_r[k] = int'(out_r0);
      got0_i[k] = int'(out_i0);
      got_idx[k] = int'(out_idx);
      got_last[k] = int'(out_last);
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_r !== 16'sd0 || out_i !== 16'sd0) begin errors++; $display("FAIL reset_out_data got (%0d,%0d) want (0,0)", out_r, out_i); end
    checks++; if (out_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_impulse0();
    gx_r = '{4, 0, 0, 0};
    gx_i = '{0, 0, 0, 0};
    run_group();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL imp0_timeout got %b want 0", tmo); end
    checks++; if (lat != 1) begin errors++; $display("FAIL imp0_latency got %0d want 1", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_r[k] != 1 || got_i[k] != 0 || got_idx[k] != k || got_last[k] != (k == 3 ? 1 : 0)) begin
        errors++;
        $display("FAIL imp0_f%0d got (%0d,%0d) idx %0d last %0d want (1,0) idx %0d last %0d",
                 k, got_r[k], got_i[k], got_idx[k], got_last[k], k, (k == 3 ? 1 : 0));
      end
    end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL imp0_idle got ready %b busy %b valid %b want 1 0 0", in_ready, busy, out_valid); end
  endtask

  task automatic test_impulse1();
    int er [4];
    int ei [4];
    er = '{1, 0, -1, 0};
    ei = '{0, 1, 0, -1};
    gx_r = '{0, 4, 0, 0};
    gx_i = '{0, 0, 0, 0};
    run_group();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL imp1_timeout got %b want 0", tmo); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_r[k] != er[k] || got_i[k] != ei[k]) begin
        errors++;
        $display("FAIL imp1_f%0d got (%0d,%0d) want (%0d,%0d)", k, got_r[k], got_i[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_floor();
    gx_r = '{-1, 0, 0, 0};
    gx_i = '{0, 0, 0, 0};
    run_group();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_r[k] != -1 || got_i[k] != 0) begin
        errors++;
        $display("FAIL floor_f%0d got (%0d,%0d) want (-1,0)", k, got_r[k], got_i[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int e0 [4];
    int e1 [4];
    e0 = '{-4, 0, 0, 0};
    e1 = '{32767, 0, 0, 0};
    gx_r = '{32767, 32767, 32767, 32767};
    gx_i = '{0, 0, 0, 0};
    run_group();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got0_r[k] != e0[k] || got0_i[k] != 0) begin
        errors++;
        $display("FAIL wrap_s0_f%0d got (%0d,%0d) want (%0d,0)", k, got0_r[k], got0_i[k], e0[k]);
      end
      checks++;
      if (got_r[k] != e1[k] || got_i[k] != 0) begin
        errors++;
        $display("FAIL wrap_s1_f%0d got (%0d,%0d) want (%0d,0)", k, got_r[k], got_i[k], e1[k]);
      end
    end
  endtask

  task automatic bp_driver();
    tmo = 1'b0;
    for (int s = 0; s < 400; s++) begin
      while ($urandom_range(0, 3) == 0) step();
      sent_r[s] = int'($signed(16'($urandom)));
      sent_i[s] = int'($signed(16'($urandom)));
      send_sample(sent_r[s], sent_i[s]);
    end
  endtask

  task automatic bp_receiver();
    int n, cyc;
    bit prev_stall, hs;
    logic signed [15:0] pr, pi, pr0, pi0;
    logic [1:0] pidx;
    logic [31:0] e1, e0;
    n = 0;
    cyc = 0;
    prev_stall = 1'b0;
    pr = '0; pi = '0; pr0 = '0; pi0 = '0; pidx = '0;
    while (n < 400 && cyc < 20000) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_r !== pr || out_i !== pi || out_idx !== pidx ||
            out_r0 !== pr0 || out_i0 !== pi0) begin
          errors++;
          $display("FAIL bp_stall_hold n %0d got v%b (%0d,%0d) idx %0d want v1 (%0d,%0d) idx %0d",
                   n, out_valid, out_r, out_i, out_idx, pr, pi, pidx);
        end
      end
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_emit got %b want 0", in_ready); end
      end
      out_ready = 1'($urandom_range(0, 1));
      hs = out_valid && out_ready;
      if (hs) begin
        e1 = mdl(n / 4, n % 4, 1'b1);
        e0 = mdl(n / 4, n % 4, 1'b0);
        checks++;
        if (out_r !== e1[31:16] || out_i !== e1[15:0] || out_idx !== 2'(n % 4) ||
            out_last !== (n % 4 == 3)) begin
          errors++;
          $display("FAIL bp_s1 n %0d got (%0d,%0d) idx %0d last %b want (%0d,%0d) idx %0d",
                   n, out_r, out_i, out_idx, out_last, $signed(e1[31:16]), $signed(e1[15:0]), n % 4);
        end
        checks++;
        if (out_r0 !== e0[31:16] || out_i0 !== e0[15:0]) begin
          errors++;
          $display("FAIL bp_s0 n %0d got (%0d,%0d) want (%0d,%0d)",
                   n, out_r0, out_i0, $signed(e0[31:16]), $signed(e0[15:0]));
        end
        n++;
      end
      prev_stall = out_valid && !out_ready;
      pr = out_r; pi = out_i; pr0 = out_r0; pi0 = out_i0; pidx = out_idx;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (n != 400) begin errors++; $display("FAIL bp_count got %0d want 400", n); end
  endtask

  task automatic test_backpressure();
    fork
      bp_driver();
      bp_receiver();
    join
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_input_timeout got %b want 0", tmo); end
  endtask

  task automatic test_reset_mid();
    int er [4];
    int ei [4];
    int c;
    tmo = 1'b0;
    send_sample(100, 100);
    send_sample(200, -300);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_partial got %b want 1", busy); end
    do_reset();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_after_collect got busy %b valid %b ready %b want 0 0 1", busy, out_valid, in_ready); end
    gx_r = '{0, 0, 4, 0};
    gx_i = '{0, 0, 0, 0};
    er = '{1, -1, 1, -1};
    run_group();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_r[k] != er[k] || got_i[k] != 0) begin
        errors++;
        $display("FAIL rmid_g1_f%0d got (%0d,%0d) want (%0d,0)", k, got_r[k], got_i[k], er[k]);
      end
    end
    // Group x3=(0,8): emit f0,f1 then reset mid-emit.
    send_sample(0, 0);
    send_sample(0, 0);
    send_sample(0, 0);
    send_sample(0, 8);
    c = 0;
    while (!out_valid && c < 20) begin step(); c++; end
    out_ready = 1'b1;
    er = '{0, 2, 0, -2};
    ei = '{2, 0, -2, 0};
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_r !== 16'(er[k]) || out_i !== 16'(ei[k])) begin
        errors++;
        $display("FAIL rmid_g2_f%0d got v%b (%0d,%0d) want v1 (%0d,%0d)", k, out_valid, out_r, out_i, er[k], ei[k]);
      end
      step();
    end
    do_reset();
    checks++; if (out_valid !== 1'b0 || out_r !== 16'sd0 || out_i !== 16'sd0 || out_idx !== 2'd0) begin errors++; $display("FAIL rmid_after_emit got v%b (%0d,%0d) idx %0d want v0 (0,0) idx 0", out_valid, out_r, out_i, out_idx); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_after_emit_ctl got busy %b ready %b want 0 1", busy, in_ready); end
    gx_r = '{4, 0, 0, 0};
    gx_i = '{0, 0, 0, 0};
    run_group();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_r[k] != 1 || got_i[k] != 0) begin
        errors++;
        $display("FAIL rmid_g3_f%0d got (%0d,%0d) want (1,0)", k, got_r[k], got_i[k]);
      end
    end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rmid_timeout got %b want 0", tmo); end
  endtask

  task automatic test_round_trip();
    int xr [8];
    int xi [8];
    int a, b, sr, si;
    xr = '{4, 8188, -8192, 400, -8192, -8192, 8188, -4};
    xi = '{-8, -8192, 8188, -1200, -8192, -8192, 8188, 12};
    for (int g = 0; g < 2; g++) begin
      // Forward butterfly: X_k = sum x_n * (-i)^(n*k).
      for (int k = 0; k < 4; k++) begin
        sr = 0;
        si = 0;
        for (int n = 0; n < 4; n++) begin
          a = xr[4*g+n];
          b = xi[4*g+n];
          case ((4 - (n * k) % 4) % 4)
            0: begin sr += a; si += b; end
            1: begin sr -= b; si += a; end
            2: begin sr -= a; si -= b; end
            default: begin sr += b; si -= a; end
          endcase
        end
        gx_r[k] = sr;
        gx_i[k] = si;
      end
      run_group();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_r[k] != xr[4*g+k] || got_i[k] != xi[4*g+k]) begin
          errors++;
          $display("FAIL rtrip_g%0d_x%0d got (%0d,%0d) want (%0d,%0d)",
                   g, k, got_r[k], got_i[k], xr[4*g+k], xi[4*g+k]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_r = '0;
    in_i = '0;
    test_reset();
    test_impulse0();
    test_impulse1();
    test_floor();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
